// File: rtl/uart_send.sv
// uart_send: 8N1 UART transmitter, LSB first, with a small byte FIFO
// that decouples the valid/ready push side from the fixed-rate line.
module uart_send #(
    parameter int CLK_FREQ   = 40_000_000,
    parameter int UART_BPS   = 128000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_txd,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int BW      = $clog2(BPS_CNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;
    logic            fifo_empty;

    logic [BW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            txd_r;
    logic            done_r;
    logic            bit_end;

    logic [BW-1:0]   cnt_nxt;
    logic [2:0]      idx_nxt;
    logic [7:0]      shift_nxt;
    logic            txd_nxt;
    logic            done_nxt;

    assign fifo_empty = (count == '0);
    assign tx_ready   = (count != CW'(FIFO_DEPTH));
    assign push       = tx_valid && tx_ready;
    assign bit_end    = (clk_cnt == BW'(BPS_CNT - 1));

    assign fifo_count = count;
    assign uart_txd   = txd_r;
    assign tx_done    = done_r;
    assign tx_busy    = (state != IDLE);

    // FIFO storage: written on an accepted push, never reset
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; push+pop together leave count unchanged
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Serializer state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: advance only at bit boundaries, chain frames while data waits
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) state_nxt = START;
            end
            START: begin
                if (bit_end) state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
            end
            STOP: begin
                if (bit_end) state_nxt = fifo_empty ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath next values: pop/load, line level, bit counters, done pulse
    always_comb begin
        pop       = 1'b0;
        txd_nxt   = txd_r;
        shift_nxt = shift;
        idx_nxt   = bit_idx;
        done_nxt  = 1'b0;
        cnt_nxt   = (state == IDLE || bit_end) ? '0 : clk_cnt + BW'(1);
        unique case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_nxt = mem[rd_ptr];
                    txd_nxt   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_nxt   = shift[0];
                    shift_nxt = {1'b0, shift[7:1]};
                    idx_nxt   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        txd_nxt = 1'b1;
                    end else begin
                        txd_nxt   = shift[0];
                        shift_nxt = {1'b0, shift[7:1]};
                        idx_nxt   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done_nxt = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        txd_nxt   = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; the line pin comes straight from txd_r
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd_r   <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            clk_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            shift   <= shift_nxt;
            txd_r   <= txd_nxt;
            done_r  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: bench for uart_send at BPS_CNT=10 with a serial
// decoder checking bytes against a queue filled on accepted pushes.
module tb_uart_send;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int UART_BPS   = 100_000;
    localparam int FIFO_DEPTH = 16;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic       tx_done;
    logic [4:0] fifo_count;

    always #5 sys_clk = ~sys_clk;

    uart_send #(
        .CLK_FREQ   (CLK_FREQ),
        .UART_BPS   (UART_BPS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .fifo_count (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         starts [$];
    int         cyc      = 0;
    int         done_cnt = 0;

    typedef struct {
        logic [7:0] d;
        logic [9:0] fr;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // scoreboard producer: bytes accepted on the edge
    initial begin
        forever begin
            @(posedge sys_clk);
            cyc++;
            if (sys_rst_n && tx_valid && tx_ready) exp_q.push_back(tx_data);
        end
    end

    // serial decoder: samples mid-bit, compares against scoreboard
    initial begin
        bit         m_busy;
        int         m_cnt;
        logic [7:0] m_byte;
        m_busy = 0;
        m_cnt  = 0;
        m_byte = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                m_busy = 0;
                exp_q.delete();
            end else begin
                if (tx_done) done_cnt++;
                if (!m_busy) begin
                    if (!uart_txd) begin
                        m_busy = 1;
                        m_cnt  = 0;
                        starts.push_back(cyc);
                    end
                end else begin
                    m_cnt++;
                    if (m_cnt % 10 == 5) begin
                        int k;
                        k = m_cnt / 10;
                        if (k == 0) begin
                            chk("start_bit", uart_txd, 0);
                        end else if (k <= 8) begin
                            m_byte[k-1] = uart_txd;
                        end else begin
                            chk("stop_bit", uart_txd, 1);
                            rx_log.push_back(m_byte);
                            if (exp_q.size() == 0) begin
                                checks++;
                                failures++;
                                $display("FAIL rx_unexpected: got byte %0d expected none",
                                         m_byte);
                            end else begin
                                chk("rx_byte", m_byte, exp_q.pop_front());
                            end
                            m_busy = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic send_single(input logic [7:0] d, input logic [9:0] fr,
                               input string nm);
        int bad_txd;
        int bad_done;
        int bad_busy;
        bad_txd  = 0;
        bad_done = 0;
        bad_busy = 0;
        @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        chk({nm, "_cnt_after_push"}, fifo_count, 1);
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 1) chk({nm, "_cnt_after_pop"}, fifo_count, 0);
            if (uart_txd !== fr[(k-1)/10]) bad_txd++;
            if (tx_done !== 1'b0) bad_done++;
            if (tx_busy !== 1'b1) bad_busy++;
        end
        chk({nm, "_frame_bits"}, bad_txd, 0);
        chk({nm, "_early_done"}, bad_done, 0);
        chk({nm, "_busy_in_frame"}, bad_busy, 0);
        tick();
        chk({nm, "_done_pulse"}, tx_done, 1);
        chk({nm, "_busy_fall"}, tx_busy, 0);
        chk({nm, "_line_idle"}, uart_txd, 1);
        tick();
        chk({nm, "_done_width"}, tx_done, 0);
    endtask

    task automatic wait_idle(input int bound, input string nm);
        int i;
        i = 0;
        while (i < bound &&
               !(tx_busy == 1'b0 && fifo_count == 0 && exp_q.size() == 0)) begin
            tick();
            i++;
        end
        chk({nm, "_drain_in_time"}, int'(i < bound), 1);
        repeat (3) tick();
    endtask

    initial begin
        int bad;
        int d0;
        int s0;
        int r0;

        vecs[0] = '{8'h55, 10'b1010101010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h80, 10'b1100000000};
        vecs[4] = '{8'h01, 10'b1000000010};
        vecs[5] = '{8'hA3, 10'b1101000110};

        // reset state
        repeat (3) tick();
        chk("rst_txd", uart_txd, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", tx_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_done", tx_done, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("idle_hold", bad, 0);
        chk("idle_no_done", done_cnt, 0);

        // single frames from the vector table
        for (int v = 0; v < 6; v++) begin
            send_single(vecs[v].d, vecs[v].fr, $sformatf("vec%0d", v));
            repeat (5) tick();
        end

        // back-to-back frames
        d0 = done_cnt;
        s0 = starts.size();
        @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        @(negedge sys_clk);
        tx_data  = 8'h00;
        @(negedge sys_clk);
        tx_data  = 8'hFF;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 290; i++) begin
            tick();
            if (tx_busy !== 1'b1) bad++;
        end
        chk("b2b_busy_gap", bad, 0);
        wait_idle(400, "b2b");
        chk("b2b_done_pulses", done_cnt - d0, 3);
        chk("b2b_frames", starts.size() - s0, 3);
        if (starts.size() - s0 == 3) begin
            chk("b2b_gap1", starts[s0+1] - starts[s0], 100);
            chk("b2b_gap2", starts[s0+2] - starts[s0+1], 100);
        end

        // full FIFO: 20 offered, 17 accepted
        r0 = rx_log.size();
        for (int j = 0; j < 20; j++) begin
            @(negedge sys_clk);
            tx_valid = 1'b1;
            tx_data  = 8'h40 + 8'(j);
            tick();
            if (j == 15) begin
                chk("full_cnt15", fifo_count, 15);
                chk("full_ready15", tx_ready, 1);
            end
            if (j == 16) begin
                chk("full_cnt16", fifo_count, 16);
                chk("full_ready16", tx_ready, 0);
            end
        end
        tx_valid = 1'b0;
        chk("full_cnt_hold", fifo_count, 16);
        chk("full_accepted", exp_q.size(), 17);
        wait_idle(2500, "full");
        chk("full_ready_back", tx_ready, 1);
        chk("full_rx_count", rx_log.size() - r0, 17);
        bad = 0;
        for (int i = 0; i < 17 && r0 + i < rx_log.size(); i++) begin
            if (rx_log[r0+i] !== 8'h40 + 8'(i)) bad++;
        end
        chk("full_rx_order", bad, 0);

        // wrap-around: 40 bytes in bursts of 10
        r0 = rx_log.size();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge sys_clk);
                tx_valid = 1'b1;
                tx_data  = 8'(b * 10 + i);
            end
            @(negedge sys_clk);
            tx_valid = 1'b0;
            wait_idle(1500, $sformatf("wrap%0d", b));
            chk($sformatf("wrap%0d_count", b), fifo_count, 0);
        end
        chk("wrap_rx_count", rx_log.size() - r0, 40);
        bad = 0;
        for (int i = 0; i < 40 && r0 + i < rx_log.size(); i++) begin
            if (rx_log[r0+i] !== 8'(i)) bad++;
        end
        chk("wrap_rx_order", bad, 0);

        // reset during DATA bit 4 with three bytes queued
        @(negedge sys_clk);
        tx_valid = 1'b1;
        tx_data  = 8'h11;
        @(negedge sys_clk);
        tx_data  = 8'h22;
        @(negedge sys_clk);
        tx_data  = 8'h33;
        @(negedge sys_clk);
        tx_data  = 8'h44;
        @(negedge sys_clk);
        tx_valid = 1'b0;
        repeat (52) @(posedge sys_clk);
        #1;
        chk("mid_queued", fifo_count, 3);
        #2;
        d0 = done_cnt;
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_txd", uart_txd, 1);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_ready", tx_ready, 1);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("mid_line_quiet", bad, 0);
        chk("mid_no_done", done_cnt - d0, 0);
        send_single(vecs[5].d, vecs[5].fr, "post_rst");
        wait_idle(300, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_send.md
# uart_send

UART transmitter, 8N1, LSB first, the transmit end of the board's serial link. A small FIFO decouples the CPU/MMIO side, which pushes bytes with a valid/ready handshake, from the fixed-rate serial line. Bit timing uses the same CLK_FREQ/UART_BPS divisor scheme as the receive path, so both ends agree on baud rate with identical parameters.

## Interface
- CLK_FREQ, 40_000_000: system clock frequency in Hz.
- UART_BPS, 128000: baud rate.
- FIFO_DEPTH, 16: transmit FIFO entries; power of two, minimum 2.
- BPS_CNT (localparam): CLK_FREQ/UART_BPS, integer-truncated (312 at defaults). This is the number of sys_clk cycles per bit.

Ports (name, direction, width, meaning):
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data is valid this cycle.
- tx_ready  out  1  FIFO can accept a byte; equals !fifo_full.
- uart_txd  out  1  serial line, registered, idles high.
- tx_busy  out  1  serializer not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes currently queued; excludes the byte being shifted.

## Operation
- Push: the byte is accepted on an edge where tx_valid && tx_ready. tx_valid while full is ignored; the byte is not stored and no error is raised.
- FIFO: circular buffer with wrapping read/write pointers and an explicit count.
  - Push and pop on the same edge leaves fifo_count unchanged.
  - A pop on empty never occurs.
- FSM states: IDLE, START, DATA, STOP. A clk_cnt counts 0..BPS_CNT-1 per bit and a 3-bit bit_idx tracks the data bit.
  - IDLE: uart_txd=1. If FIFO is non-empty: pop into shift register, uart_txd<=0, clk_cnt<=0, go to START.
  - START: at clk_cnt==BPS_CNT-1, uart_txd<=shift[0], bit_idx<=0, go to DATA.
  - DATA: at clk_cnt==BPS_CNT-1, if bit_idx==7 then uart_txd<=1 and go to STOP; otherwise drive the next bit and increment bit_idx.
  - STOP: at clk_cnt==BPS_CNT-1, tx_done<=1. If FIFO is non-empty, pop, uart_txd<=0 and go to START, with no idle gap between frames. Otherwise go to IDLE.
- Frame: 10*BPS_CNT cycles. Each line level is held for exactly BPS_CNT cycles.
- The shift register is loaded once per frame, so FIFO pushes mid-frame never disturb the current frame.

## Timing
- Reset values: uart_txd=1, tx_busy=0, tx_done=0, fifo_count=0, tx_ready=1, state=IDLE, FIFO pointers 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronous) and queued bytes are discarded.
- Latency: a byte accepted at edge N into an empty FIFO with FSM in IDLE drives uart_txd low after edge N+1. fifo_count is 1 after N and 0 after N+1.
- tx_busy rises with the start bit.
- tx_busy falls on the same edge as tx_done only when the FIFO is empty. Otherwise it stays high across back-to-back frames.
- tx_done is high for exactly one cycle per frame.
- tx_ready falls on the edge fifo_count reaches FIFO_DEPTH. It rises on the edge after the next pop.
- Full FIFO with simultaneous pop: push is refused that cycle because tx_ready was low. tx_ready=1 the following cycle.
- uart_txd comes only from a flop, so no combinational glitches reach the pin.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, UART_BPS=100_000, so BPS_CNT=10.
- Reset check: hold sys_rst_n low -> uart_txd=1, tx_busy=0, tx_ready=1, fifo_count=0. After release the line stays 1 indefinitely with no pushes.
- Single byte: push 0x55 at edge N. Required response:
  - uart_txd low from N+1 for 10 cycles.
  - Then 1,0,1,0,1,0,1,0 at 10 cycles each.
  - Stop 1 for 10 cycles.
  - tx_done pulses once at N+101.
  - tx_busy low after that edge.
  - A loopback into uart_recv yields 0x55.
- Back-to-back: push 0xA3, 0x00, 0xFF on consecutive cycles -> three contiguous frames of 100 cycles each with no idle gap, exactly 3 tx_done pulses, and the decoded bytes in order.
- Full FIFO: hold tx_valid with 17+ pushes while the first frame shifts. Required response:
  - tx_ready deasserts when fifo_count=16.
  - Bytes offered while tx_ready=0 are dropped.
  - The first 17 accepted bytes are transmitted in order.
- Wrap-around: push and drain 40 incrementing bytes 0x00..0x27 in bursts of 10 -> the serial output equals the input sequence exactly and fifo_count returns to 0.
- Reset mid-frame: assert sys_rst_n during DATA bit 4 with 3 bytes queued. Required response:
  - uart_txd=1 immediately and fifo_count=0.
  - No tx_done pulse.
  - A fresh push after release transmits a correct full frame.
